// File: rtl/throw_pkg.sv
// ============================================================================
//  Module   : throw_pkg
//  Purpose  : Shared throw-meter state encoding and default power/bar sizing.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package throw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        LAUNCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Defaults shared with the projectile and HUD blocks
    localparam int DEF_PWR_MAX   = 100;
    localparam int DEF_PWR_W     = 7;
    localparam int DEF_BAR_SCALE = 2;
    localparam int DEF_BAR_W     = 10;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
//  Module   : tick_gen
//  Purpose  : Free-running divider; one-cycle tick every DIV enabled cycles.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;
    logic          at_top;

    assign at_top = (count == CW'(DIV - 1));
    assign tick   = en && at_top;

    // Dropping enable restarts the period so each charge starts from a fresh count
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count <= '0;
        end else if (at_top) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/throw_power_meter.sv
// ============================================================================
//  Module   : throw_power_meter
//  Purpose  : Ping-pong power meter; latches power on release, hands off over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module throw_power_meter
    import throw_pkg::*;
#(
    parameter int CLK_HZ    = 65000000,
    parameter int STEP_HZ   = 100,
    parameter int PWR_MAX   = DEF_PWR_MAX,
    parameter int PWR_W     = DEF_PWR_W,
    parameter int BAR_SCALE = DEF_BAR_SCALE,
    parameter int BAR_W     = DEF_BAR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dog_turn,
    input  logic             enable_draw,
    input  logic             throw_enable,
    input  logic             throw_ready,
    output logic             throw_valid,
    output logic [PWR_W-1:0] throw_power,
    output logic [PWR_W-1:0] power,
    output logic [BAR_W-1:0] power_bar,
    output logic             meter_visible
);

    localparam int TICK_DIV = CLK_HZ / STEP_HZ;

    state_t           state, state_next;
    logic             dir_down, dir_down_next;
    logic [PWR_W-1:0] power_next;
    logic [PWR_W-1:0] throw_power_next;
    logic             tick_en;
    logic             tick;

    // Counter only runs while charging continues, so any exit leaves it at zero
    assign tick_en = (state == CHARGE) && dog_turn && enable_draw;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_next       = state;
        dir_down_next    = dir_down;
        power_next       = power;
        throw_power_next = throw_power;

        if (!dog_turn) begin
            state_next       = IDLE;
            dir_down_next    = 1'b0;
            power_next       = '0;
            throw_power_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    dir_down_next = 1'b0;
                    power_next    = '0;
                    if (enable_draw) begin
                        state_next = CHARGE;
                    end
                end

                CHARGE: begin
                    if (!enable_draw) begin
                        // Release takes the pre-tick value; tick is gated off anyway
                        if (throw_enable) begin
                            throw_power_next = power;
                            state_next       = LAUNCH;
                        end else begin
                            state_next    = IDLE;
                            dir_down_next = 1'b0;
                            power_next    = '0;
                        end
                    end else if (tick) begin
                        if (!dir_down) begin
                            if (power == PWR_W'(PWR_MAX)) begin
                                dir_down_next = 1'b1;
                                power_next    = PWR_W'(PWR_MAX - 1);
                            end else begin
                                power_next = power + PWR_W'(1);
                            end
                        end else begin
                            if (power == '0) begin
                                dir_down_next = 1'b0;
                                power_next    = PWR_W'(1);
                            end else begin
                                power_next = power - PWR_W'(1);
                            end
                        end
                    end
                end

                LAUNCH: begin
                    if (throw_ready) begin
                        state_next = DONE;
                    end
                end

                DONE: begin
                    if (!throw_enable) begin
                        state_next    = IDLE;
                        dir_down_next = 1'b0;
                        power_next    = '0;
                    end
                end

                default: begin
                    state_next = IDLE;
                    power_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dir_down      <= 1'b0;
            power         <= '0;
            power_bar     <= '0;
            throw_power   <= '0;
            throw_valid   <= 1'b0;
            meter_visible <= 1'b0;
        end else begin
            state         <= state_next;
            dir_down      <= dir_down_next;
            power         <= power_next;
            power_bar     <= BAR_W'(power_next) * BAR_W'(BAR_SCALE);
            throw_power   <= throw_power_next;
            throw_valid   <= (state_next == LAUNCH);
            meter_visible <= (state_next != IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_throw_power_meter.sv
// ============================================================================
//  Module   : tb_throw_power_meter
//  Purpose  : Directed scenarios plus random stimulus against a triangle-wave reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_throw_power_meter;

    localparam int CLK_HZ    = 1000;
    localparam int STEP_HZ   = 100;
    localparam int DIV       = CLK_HZ / STEP_HZ;
    localparam int PWR_MAX   = 100;
    localparam int PWR_W     = 7;
    localparam int BAR_SCALE = 2;
    localparam int BAR_W     = 10;

    localparam int M_IDLE   = 0;
    localparam int M_CHARGE = 1;
    localparam int M_LAUNCH = 2;
    localparam int M_DONE   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dog_turn = 1'b1;
    logic             enable_draw = 1'b0;
    logic             throw_enable = 1'b0;
    logic             throw_ready = 1'b0;
    logic             throw_valid;
    logic [PWR_W-1:0] throw_power;
    logic [PWR_W-1:0] power;
    logic [BAR_W-1:0] power_bar;
    logic             meter_visible;

    int errors = 0;
    int checks = 0;

    // Reference: state plus count of charge cycles; power is a triangle wave of n/DIV
    int m_state = M_IDLE;
    int m_n     = 0;
    int m_tp    = 0;

    throw_power_meter #(
        .CLK_HZ    (CLK_HZ),
        .STEP_HZ   (STEP_HZ),
        .PWR_MAX   (PWR_MAX),
        .PWR_W     (PWR_W),
        .BAR_SCALE (BAR_SCALE),
        .BAR_W     (BAR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dog_turn      (dog_turn),
        .enable_draw   (enable_draw),
        .throw_enable  (throw_enable),
        .throw_ready   (throw_ready),
        .throw_valid   (throw_valid),
        .throw_power   (throw_power),
        .power         (power),
        .power_bar     (power_bar),
        .meter_visible (meter_visible)
    );

    always #5 clk = ~clk;

    function automatic int tri_pwr(int steps);
        int p;
        p = steps % (2 * PWR_MAX);
        return (p <= PWR_MAX) ? p : (2 * PWR_MAX - p);
    endfunction

    function automatic int exp_power();
        return (m_state == M_IDLE) ? 0 : tri_pwr(m_n / DIV);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst || !dog_turn) begin
            m_state = M_IDLE;
            m_n     = 0;
            m_tp    = 0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    m_n = 0;
                    if (enable_draw) m_state = M_CHARGE;
                end
                M_CHARGE: begin
                    if (enable_draw) begin
                        m_n++;
                    end else if (throw_enable) begin
                        m_tp    = tri_pwr(m_n / DIV);
                        m_state = M_LAUNCH;
                    end else begin
                        m_state = M_IDLE;
                        m_n     = 0;
                    end
                end
                M_LAUNCH: if (throw_ready) m_state = M_DONE;
                default:  if (!throw_enable) begin m_state = M_IDLE; m_n = 0; end
            endcase
        end
    endtask

    task automatic compare_all();
        check("power",         int'(power),         exp_power());
        check("power_bar",     int'(power_bar),     exp_power() * BAR_SCALE);
        check("throw_valid",   int'(throw_valid),   int'(m_state == M_LAUNCH));
        check("throw_power",   int'(throw_power),   m_tp);
        check("meter_visible", int'(meter_visible), int'(m_state != M_IDLE));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    // Enter CHARGE, hold for n further charge cycles, then release with throw window open
    task automatic charge_release(input int n);
        enable_draw  = 1'b1;
        throw_enable = 1'b1;
        cycles(1 + n);
        enable_draw = 1'b0;
        cycles(1);
    endtask

    task automatic finish_throw();
        throw_ready = 1'b1;
        cycles(1);
        throw_ready  = 1'b0;
        throw_enable = 1'b0;
        cycles(1);
    endtask

    initial begin
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);

        // Charge 250 cycles and release
        charge_release(250);
        check("s2_throw_power", int'(throw_power), 25);
        check("s2_power_bar",   int'(power_bar),   50);
        check("s2_valid",       int'(throw_valid), 1);
        finish_throw();
        check("s2_idle_visible", int'(meter_visible), 0);

        // Ping-pong past the top
        enable_draw  = 1'b1;
        throw_enable = 1'b1;
        cycles(1 + 1000);
        check("s3_peak", int'(power), 100);
        cycles(10);
        check("s3_turn", int'(power), 99);
        cycles(40);
        enable_draw = 1'b0;
        cycles(1);
        check("s3_throw_power", int'(throw_power), 95);
        finish_throw();

        // Past zero and back up
        enable_draw = 1'b1;
        cycles(1 + 2010);
        check("s3_bottom_bounce", int'(power), 1);
        enable_draw = 1'b0;
        cycles(1);

        // Release on the exact tick cycle: pre-tick value wins
        charge_release(DIV * 41 - 1);
        check("s4_tick_release", int'(throw_power), 40);

        // Abort mid-LAUNCH without ready
        dog_turn = 1'b0;
        cycles(1);
        check("s5_abort_valid", int'(throw_valid), 0);
        check("s5_abort_power", int'(power), 0);
        dog_turn     = 1'b1;
        throw_enable = 1'b0;
        cycles(2);

        // Release with no throw window
        enable_draw = 1'b1;
        cycles(31);
        enable_draw = 1'b0;
        cycles(1);
        check("s5_norelease_valid", int'(throw_valid), 0);
        check("s5_norelease_vis",   int'(meter_visible), 0);

        // Back-pressure: 50 cycles with ready low
        charge_release(123);
        cycles(50);
        check("s6_hold_valid", int'(throw_valid), 1);
        check("s6_hold_power", int'(throw_power), 12);
        finish_throw();

        // Reset mid-CHARGE then restart from zero
        enable_draw = 1'b1;
        cycles(78);
        rst = 1'b1;
        cycles(3);
        check("s1_reset_power", int'(power), 0);
        check("s1_reset_vis",   int'(meter_visible), 0);
        rst = 1'b0;
        cycles(1 + DIV);
        check("s1_restart", int'(power), 1);
        enable_draw = 1'b0;
        cycles(1);

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) < 3)   enable_draw  = ~enable_draw;
            if ($urandom_range(0, 99) < 4)   throw_enable = ~throw_enable;
            throw_ready = ($urandom_range(0, 99) < 20);
            dog_turn    = ($urandom_range(0, 999) >= 5);
            rst         = ($urandom_range(0, 999) < 2);
            cycles(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/throw_power_meter.md
Name: throw_power_meter

Overview:
- Downstream consumer of the local-turn FSM outputs (enable_draw, throw_enable); sits between that FSM and the projectile/trajectory block.
- While the player holds space (enable_draw=1), a power value ping-pongs 0..PWR_MAX at a fixed step rate.
- On release it latches the power and hands it to the projectile block over a valid/ready handshake.
- Also drives a bar length for the HUD renderer.

Parameters:
- CLK_HZ, 65000000, system clock frequency.
- STEP_HZ, 100, power steps per second; TICK_DIV = CLK_HZ/STEP_HZ (integer, >=2).
- PWR_MAX, 100, top of the power range (inclusive).
- PWR_W, 7, power width; must satisfy 2**PWR_W > PWR_MAX.
- BAR_SCALE, 2, pixels per power unit.
- BAR_W, 10, bar width field; must hold PWR_MAX*BAR_SCALE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dog_turn  in  1  local player's turn; low = abort
- enable_draw  in  1  space held (charging)
- throw_enable  in  1  release/throw window from turn FSM
- throw_ready  in  1  projectile block accepts launch
- throw_valid  out  1  launch request, latched power valid
- throw_power  out  PWR_W  latched launch power
- power  out  PWR_W  live meter value
- power_bar  out  BAR_W  power*BAR_SCALE, for HUD
- meter_visible  out  1  HUD shows bar (any state except IDLE)

Behaviour:
- Clock and reset: clk is the clock; rst is synchronous, active-high.
- Reset values: state IDLE; all outputs 0; tick counter 0; direction up.
- Outputs are registered. power_bar is registered from the same next-value as power, so both update on the same edge.
- State machine, states: IDLE, CHARGE, LAUNCH, DONE.
- IDLE:
  - power=0, dir=up, tick counter held at 0.
  - enable_draw=1 moves to CHARGE.
- CHARGE:
  - Tick counter runs 0..TICK_DIV-1; a tick fires on the cycle it equals TICK_DIV-1, and the counter then wraps to 0.
  - On tick, dir up: power<PWR_MAX gives power+1; power==PWR_MAX gives dir=down and power=PWR_MAX-1.
  - On tick, dir down: power>0 gives power-1; power==0 gives dir=up and power=1.
- Leaving CHARGE:
  - enable_draw=0 with throw_enable=1: throw_power<=power (the pre-tick value if a tick coincides; release wins over the tick). Go to LAUNCH.
  - enable_draw=0 with throw_enable=0: abort to IDLE with power cleared.
- LAUNCH:
  - throw_valid=1; throw_power stable; power frozen; no ticks.
  - throw_ready=1 sampled while throw_valid=1: throw_valid<=0 next cycle, go to DONE.
  - throw_ready already high on LAUNCH entry gives a one-cycle valid pulse.
- DONE:
  - throw_power and power hold.
  - throw_enable=0 moves to IDLE; power cleared on entry to IDLE.
- meter_visible=1 in CHARGE, LAUNCH and DONE.
- dog_turn=0 in any state:
  - Next cycle: IDLE, all outputs 0, counter 0.
  - This has priority over every transition, including mid-LAUNCH: valid drops without ready. This is the only allowed valid withdrawal.
- enable_draw re-asserted while in LAUNCH/DONE: ignored until IDLE is reached.
- No arithmetic overflow: power stays within 0..PWR_MAX by construction. power_bar is computed unsigned and zero-extended to BAR_W.

Decomposition:
- throw_pkg holds:
  - the state enum (IDLE, CHARGE, LAUNCH, DONE; 2-bit);
  - default PWR_MAX, PWR_W and BAR_SCALE localparams, shared with the projectile and HUD blocks.
- Sub-module tick_gen:
  - parameter DIV;
  - ports clk, rst, en, tick;
  - counter clears when en=0.

Test Plan:
- Bench config for all scenarios: CLK_HZ=1000, STEP_HZ=100 (TICK_DIV=10), PWR_MAX=100, BAR_SCALE=2.
- Scenario 1, reset: assert rst for 3 cycles mid-CHARGE -> all outputs 0, state IDLE, next enable_draw restarts from power=0.
- Scenario 2, charge and release: enable_draw held 250 cycles, then enable_draw=0 with throw_enable=1 the same cycle -> power=25, power_bar=50, throw_valid=1, throw_power=25; throw_ready one cycle later -> throw_valid=0, DONE; throw_enable=0 -> IDLE, meter_visible=0.
- Scenario 3, ping-pong: hold 1050 cycles -> power reaches 100 at tick 100, tick 101 gives 99, release at 1050 -> throw_power=95. Hold 2010 cycles -> passes 0, then 1 (dir up).
- Scenario 4, simultaneous tick and release: release on the cycle tick_gen fires with power=40 -> throw_power=40, not 41.
- Scenario 5, aborts:
  - dog_turn drops in LAUNCH with throw_ready=0 -> throw_valid=0 next cycle, IDLE, power=0.
  - enable_draw falls with throw_enable=0 -> IDLE, no throw_valid.
- Scenario 6, back-pressure: throw_ready held 0 for 50 cycles in LAUNCH -> throw_valid and throw_power stable throughout, power frozen, no ticks.
